// File: rtl/l2_tag_pkg.sv
// Shared widths, issuer FSM encoding and address split helper for the L2 tag front end.
package l2_tag_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int SET_W    = 9;
    localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W;
    localparam int STATE_W  = 3;
    localparam int CNT_W    = 4;
    localparam int WAY_W    = 4;
    localparam int LAT_MAX  = 7;

    // Fixed encodings so state values stay stable for existing debug tooling.
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ISSUE       = 3'd1;
    localparam logic [2:0] ST_WAIT_WAY    = 3'd2;
    localparam logic [2:0] ST_RESP        = 3'd3;
    localparam logic [2:0] ST_FLUSH_ISSUE = 3'd4;
    localparam logic [2:0] ST_FLUSH_WAIT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE        = ST_IDLE,
        S_ISSUE       = ST_ISSUE,
        S_WAIT_WAY    = ST_WAIT_WAY,
        S_RESP        = ST_RESP,
        S_FLUSH_ISSUE = ST_FLUSH_ISSUE,
        S_FLUSH_WAIT  = ST_FLUSH_WAIT
    } iss_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [ADDR_W-1:0] addr);
        addr_split_t s;
        s.tag = addr[ADDR_W-1 -: TAG_W];
        s.set = addr[OFFSET_W +: SET_W];
        return s;
    endfunction

endpackage

// File: rtl/l2_tag_lat_watchdog.sv
// Counts cycles spent waiting for the bank's way result and raises a sticky
// timeout once the wait reaches LAT_MAX cycles without an answer.
module l2_tag_lat_watchdog #(
    parameter int LAT_MAX = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic done,
    output logic err_timeout
);

    localparam int              CW        = $clog2(LAT_MAX + 1);
    localparam logic [CW-1:0]   LAT_MAX_C = CW'(LAT_MAX);
    localparam logic [CW-1:0]   LAT_LAST  = LAT_MAX_C - 1'b1;

    logic [CW-1:0] cnt_reg;
    logic          err_reg;

    // The error is raised on the edge where the count becomes LAT_MAX, so an
    // answer arriving exactly LAT_MAX cycles after issue is still on time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (start) begin
            cnt_reg <= '0;
        end else if (active && !done) begin
            if (cnt_reg != LAT_MAX_C) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (cnt_reg >= LAT_LAST) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_timeout = err_reg;

endmodule

// File: rtl/l2_tag_req_issuer.sv
// Sequencer in front of the L2 tag bank: splits client addresses, drives the bank
// flex channels with one request and one flush in flight, and flags protocol errors.
module l2_tag_req_issuer #(
    parameter int ADDR_W   = l2_tag_pkg::ADDR_W,
    parameter int OFFSET_W = l2_tag_pkg::OFFSET_W,
    parameter int SET_W    = l2_tag_pkg::SET_W,
    parameter int STATE_W  = l2_tag_pkg::STATE_W,
    parameter int CNT_W    = l2_tag_pkg::CNT_W,
    parameter int WAY_W    = l2_tag_pkg::WAY_W,
    parameter int LAT_MAX  = l2_tag_pkg::LAT_MAX
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic                              req_has_state,
    input  logic [STATE_W-1:0]                req_state,
    input  logic                              req_has_cnt,
    input  logic [CNT_W-1:0]                  req_cnt,
    input  logic                              flush_req_valid,
    output logic                              flush_req_ready,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [WAY_W-1:0]                  rsp_way,
    output logic                              flush_done,
    output logic                              tag_in_valid,
    input  logic                              tag_in_ready,
    output logic [ADDR_W-SET_W-OFFSET_W-1:0]  tag_in,
    output logic                              set_in_valid,
    input  logic                              set_in_ready,
    output logic [SET_W-1:0]                  set_in,
    output logic                              state_in_valid,
    input  logic                              state_in_ready,
    output logic [STATE_W-1:0]                state_in,
    output logic                              inv_ack_cnt_in_valid,
    input  logic                              inv_ack_cnt_in_ready,
    output logic [CNT_W-1:0]                  inv_ack_cnt_in,
    input  logic                              way_out_valid,
    output logic                              way_out_ready,
    input  logic [WAY_W-1:0]                  way_out,
    output logic                              flush_in_valid,
    input  logic                              flush_in_ready,
    input  logic                              flush_complete_valid,
    output logic                              flush_complete_ready,
    output logic                              err_timeout,
    output logic                              err_spurious
);

    import l2_tag_pkg::*;

    localparam int TAG_W = ADDR_W - SET_W - OFFSET_W;

    iss_state_e          state_reg;
    iss_state_e          state_next;

    logic [TAG_W-1:0]    tag_reg;
    logic [SET_W-1:0]    set_reg;
    logic [STATE_W-1:0]  state_val_reg;
    logic [CNT_W-1:0]    cnt_val_reg;
    logic                has_state_reg;
    logic                has_cnt_reg;
    logic                rsp_valid_reg;
    logic [WAY_W-1:0]    rsp_way_reg;
    logic                flush_in_valid_reg;
    logic                flush_done_reg;
    logic                err_spurious_reg;

    logic                in_idle;
    logic                go;
    logic                issue_fire;
    logic                accept_req;
    logic                accept_flush;
    logic                way_hit;
    logic                flush_hs;
    logic                flush_cpl;

    assign in_idle = (state_reg == S_IDLE);

    // Readies are gated by reset so the client sees nothing while the block is held.
    assign flush_req_ready = in_idle & rst;
    assign req_ready       = in_idle & ~flush_req_valid & rst;
    assign accept_flush    = flush_req_ready & flush_req_valid;
    assign accept_req      = req_ready & req_valid;

    // Optional channels only hold back the issue when the request actually uses them.
    assign go = tag_in_ready & set_in_ready
              & (~has_state_reg | state_in_ready)
              & (~has_cnt_reg   | inv_ack_cnt_in_ready);

    assign issue_fire           = (state_reg == S_ISSUE) & go;
    assign tag_in_valid         = issue_fire;
    assign set_in_valid         = issue_fire;
    assign state_in_valid       = issue_fire & has_state_reg;
    assign inv_ack_cnt_in_valid = issue_fire & has_cnt_reg;

    assign way_out_ready        = (state_reg == S_WAIT_WAY);
    assign flush_complete_ready = (state_reg == S_FLUSH_WAIT);
    assign way_hit              = way_out_ready & way_out_valid;
    assign flush_cpl            = flush_complete_ready & flush_complete_valid;
    assign flush_hs             = flush_in_valid_reg & flush_in_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (flush_req_valid) begin
                    state_next = S_FLUSH_ISSUE;
                end else if (req_valid) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (go) state_next = S_WAIT_WAY;
            end
            S_WAIT_WAY: begin
                if (way_out_valid) state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            S_FLUSH_ISSUE: begin
                if (flush_hs) state_next = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                if (flush_complete_valid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Payload is captured once on acceptance and held until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_reg       <= '0;
            set_reg       <= '0;
            state_val_reg <= '0;
            cnt_val_reg   <= '0;
            has_state_reg <= 1'b0;
            has_cnt_reg   <= 1'b0;
        end else if (accept_req) begin
            tag_reg       <= req_addr[ADDR_W-1 -: TAG_W];
            set_reg       <= req_addr[OFFSET_W +: SET_W];
            state_val_reg <= req_state;
            cnt_val_reg   <= req_cnt;
            has_state_reg <= req_has_state;
            has_cnt_reg   <= req_has_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_way_reg   <= '0;
        end else if (way_hit) begin
            rsp_valid_reg <= 1'b1;
            rsp_way_reg   <= way_out;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_in_valid_reg <= 1'b0;
            flush_done_reg     <= 1'b0;
        end else begin
            if (accept_flush) begin
                flush_in_valid_reg <= 1'b1;
            end else if (flush_hs) begin
                flush_in_valid_reg <= 1'b0;
            end
            flush_done_reg <= flush_cpl;
        end
    end

    // Any bank response arriving while nothing is waiting for it is a protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_spurious_reg <= 1'b0;
        end else if ((way_out_valid && !way_out_ready) ||
                     (flush_complete_valid && !flush_complete_ready)) begin
            err_spurious_reg <= 1'b1;
        end
    end

    l2_tag_lat_watchdog #(
        .LAT_MAX (LAT_MAX)
    ) u_lat_watchdog (
        .clk         (clk),
        .rst         (rst),
        .start       (issue_fire),
        .active      (way_out_ready),
        .done        (way_out_valid),
        .err_timeout (err_timeout)
    );

    assign tag_in         = tag_reg;
    assign set_in         = set_reg;
    assign state_in       = state_val_reg;
    assign inv_ack_cnt_in = cnt_val_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_way        = rsp_way_reg;
    assign flush_in_valid = flush_in_valid_reg;
    assign flush_done     = flush_done_reg;
    assign err_spurious   = err_spurious_reg;

endmodule

// File: tb/tb_l2_tag_req_issuer.sv
// Self-checking bench for l2_tag_req_issuer: table vectors, flush/reset sequences
// and randomized transactions against an arithmetic reference model.
module tb_l2_tag_req_issuer;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int SET_W    = 9;
    localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W;
    localparam int STATE_W  = 3;
    localparam int CNT_W    = 4;
    localparam int WAY_W    = 4;
    localparam int LAT_MAX  = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic               req_has_state = 1'b0;
    logic [STATE_W-1:0] req_state = '0;
    logic               req_has_cnt = 1'b0;
    logic [CNT_W-1:0]   req_cnt = '0;
    logic               flush_req_valid = 1'b0;
    logic               flush_req_ready;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [WAY_W-1:0]   rsp_way;
    logic               flush_done;
    logic               tag_in_valid;
    logic               tag_in_ready = 1'b0;
    logic [TAG_W-1:0]   tag_in;
    logic               set_in_valid;
    logic               set_in_ready = 1'b0;
    logic [SET_W-1:0]   set_in;
    logic               state_in_valid;
    logic               state_in_ready = 1'b0;
    logic [STATE_W-1:0] state_in;
    logic               inv_ack_cnt_in_valid;
    logic               inv_ack_cnt_in_ready = 1'b0;
    logic [CNT_W-1:0]   inv_ack_cnt_in;
    logic               way_out_valid = 1'b0;
    logic               way_out_ready;
    logic [WAY_W-1:0]   way_out = '0;
    logic               flush_in_valid;
    logic               flush_in_ready = 1'b0;
    logic               flush_complete_valid = 1'b0;
    logic               flush_complete_ready;
    logic               err_timeout;
    logic               err_spurious;

    int checks = 0;
    int errors = 0;
    logic err_model = 1'b0;

    always #5 clk = ~clk;

    l2_tag_req_issuer dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_addr             (req_addr),
        .req_has_state        (req_has_state),
        .req_state            (req_state),
        .req_has_cnt          (req_has_cnt),
        .req_cnt              (req_cnt),
        .flush_req_valid      (flush_req_valid),
        .flush_req_ready      (flush_req_ready),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_way              (rsp_way),
        .flush_done           (flush_done),
        .tag_in_valid         (tag_in_valid),
        .tag_in_ready         (tag_in_ready),
        .tag_in               (tag_in),
        .set_in_valid         (set_in_valid),
        .set_in_ready         (set_in_ready),
        .set_in               (set_in),
        .state_in_valid       (state_in_valid),
        .state_in_ready       (state_in_ready),
        .state_in             (state_in),
        .inv_ack_cnt_in_valid (inv_ack_cnt_in_valid),
        .inv_ack_cnt_in_ready (inv_ack_cnt_in_ready),
        .inv_ack_cnt_in       (inv_ack_cnt_in),
        .way_out_valid        (way_out_valid),
        .way_out_ready        (way_out_ready),
        .way_out              (way_out),
        .flush_in_valid       (flush_in_valid),
        .flush_in_ready       (flush_in_ready),
        .flush_complete_valid (flush_complete_valid),
        .flush_complete_ready (flush_complete_ready),
        .err_timeout          (err_timeout),
        .err_spurious         (err_spurious)
    );

    typedef struct {
        logic [31:0] addr;
        logic        hs;
        logic [2:0]  st;
        logic        hc;
        logic [3:0]  cn;
        int          stall;
        int          sel;
        int          lat;
        logic [3:0]  way;
        int          rdly;
        logic [31:0] exp_tag;
        logic [31:0] exp_set;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    // Reference split: plain integer division of the byte address.
    function automatic logic [31:0] model_tag(input logic [31:0] a);
        return a / (32'd1 << (OFFSET_W + SET_W));
    endfunction

    function automatic logic [31:0] model_set(input logic [31:0] a);
        return (a / (32'd1 << OFFSET_W)) % (32'd1 << SET_W);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_all_zero(input string tagname);
        chk({tagname, "_req_ready"}, req_ready, 0);
        chk({tagname, "_flush_req_ready"}, flush_req_ready, 0);
        chk({tagname, "_rsp_valid"}, rsp_valid, 0);
        chk({tagname, "_rsp_way"}, rsp_way, 0);
        chk({tagname, "_flush_done"}, flush_done, 0);
        chk({tagname, "_valids"}, {tag_in_valid, set_in_valid, state_in_valid, inv_ack_cnt_in_valid}, 0);
        chk({tagname, "_payload"}, {tag_in, set_in, state_in, inv_ack_cnt_in}, 0);
        chk({tagname, "_bank_readies"}, {way_out_ready, flush_complete_ready}, 0);
        chk({tagname, "_flush_in_valid"}, flush_in_valid, 0);
        chk({tagname, "_errs"}, {err_timeout, err_spurious}, 0);
    endtask

    task automatic send_req(input logic [31:0] addr, input logic hs, input logic [2:0] st,
                            input logic hc, input logic [3:0] cn);
        req_valid = 1'b1;
        req_addr = addr;
        req_has_state = hs;
        req_state = st;
        req_has_cnt = hc;
        req_cnt = cn;
        settle();
        chk("req_ready_idle", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        req_addr = $urandom;
        req_state = 3'($urandom);
        req_cnt = 4'($urandom);
    endtask

    task automatic run_issue(input logic hs, input logic [2:0] st, input logic hc, input logic [3:0] cn,
                             input int stall, input int sel_in,
                             input logic [31:0] exp_tag, input logic [31:0] exp_set);
        int sel;
        logic stall_ok;
        sel = sel_in;
        if ((sel == 2 && !hs) || (sel == 3 && !hc)) sel = 1;
        stall_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tag_in_ready = (sel != 0);
            set_in_ready = (sel != 1);
            state_in_ready = (sel != 2);
            inv_ack_cnt_in_ready = (sel != 3);
            settle();
            if (tag_in_valid || set_in_valid || state_in_valid || inv_ack_cnt_in_valid) stall_ok = 1'b0;
            cyc();
        end
        chk("stall_no_valid", stall_ok, 1);
        tag_in_ready = 1'b1;
        set_in_ready = 1'b1;
        state_in_ready = hs ? 1'b1 : 1'($urandom);
        inv_ack_cnt_in_ready = hc ? 1'b1 : 1'($urandom);
        settle();
        chk("issue_tag_set_valid", {tag_in_valid, set_in_valid}, 2'b11);
        chk("issue_opt_valids", {state_in_valid, inv_ack_cnt_in_valid}, {hs, hc});
        chk("issue_tag", tag_in, exp_tag);
        chk("issue_set", set_in, exp_set);
        if (hs) chk("issue_state", state_in, st);
        if (hc) chk("issue_cnt", inv_ack_cnt_in, cn);
        cyc();
        settle();
        chk("issue_one_cycle", {tag_in_valid, set_in_valid, state_in_valid, inv_ack_cnt_in_valid}, 0);
        chk("wait_way_ready", way_out_ready, 1);
        tag_in_ready = 1'b0;
        set_in_ready = 1'b0;
        state_in_ready = 1'b0;
        inv_ack_cnt_in_ready = 1'b0;
    endtask

    task automatic run_way(input int lat, input logic [3:0] way, input logic exp_err);
        for (int j = 1; j < lat; j++) begin
            way_out = ~way;
            cyc();
        end
        way_out_valid = 1'b1;
        way_out = way;
        cyc();
        way_out_valid = 1'b0;
        way_out = ~way;
        settle();
        chk("rsp_valid_set", rsp_valid, 1);
        chk("rsp_way", rsp_way, way);
        chk("err_timeout", err_timeout, exp_err);
    endtask

    task automatic run_rsp(input int dly, input logic [3:0] way);
        logic hold_ok;
        hold_ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
            cyc();
            settle();
            if (!(rsp_valid === 1'b1 && rsp_way === way && req_ready === 1'b0)) hold_ok = 1'b0;
        end
        chk("rsp_hold", hold_ok, 1);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        settle();
        chk("no_accept_during_rsp", req_ready, 0);
        cyc();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        settle();
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    task automatic do_txn(input int id, input vec_t v);
        send_req(v.addr, v.hs, v.st, v.hc, v.cn);
        run_issue(v.hs, v.st, v.hc, v.cn, v.stall, v.sel, v.exp_tag, v.exp_set);
        run_way(v.lat, v.way, v.exp_err);
        run_rsp(v.rdly, v.way);
        $display("txn %0d addr=%08h hs=%0d hc=%0d stall=%0d lat=%0d way=%0h", id, v.addr, v.hs, v.hc, v.stall, v.lat, v.way);
    endtask

    task automatic do_flush(input int id, input int issue_dly, input int cpl_dly, input logic with_req,
                            input logic [31:0] addr);
        logic hold_ok;
        flush_req_valid = 1'b1;
        req_valid = with_req;
        req_addr = addr;
        req_has_state = 1'b0;
        req_has_cnt = 1'b0;
        settle();
        chk("flush_req_ready", flush_req_ready, 1);
        chk("req_blocked_by_flush", req_ready, 0);
        cyc();
        flush_req_valid = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < issue_dly; i++) begin
            flush_in_ready = 1'b0;
            settle();
            if (!(flush_in_valid === 1'b1 && req_ready === 1'b0)) hold_ok = 1'b0;
            cyc();
        end
        chk("flush_in_hold", hold_ok, 1);
        flush_in_ready = 1'b1;
        settle();
        chk("flush_in_valid", flush_in_valid, 1);
        cyc();
        flush_in_ready = 1'b0;
        settle();
        chk("flush_in_dropped", flush_in_valid, 0);
        chk("flush_wait_ready", {flush_complete_ready, req_ready}, 2'b10);
        for (int i = 0; i < cpl_dly; i++) cyc();
        flush_complete_valid = 1'b1;
        cyc();
        flush_complete_valid = 1'b0;
        settle();
        chk("flush_done_pulse", flush_done, 1);
        chk("idle_after_flush", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        if (!with_req) begin
            settle();
            chk("flush_done_one_cycle", flush_done, 0);
        end
        $display("flush %0d issue_dly=%0d cpl_dly=%0d with_req=%0d", id, issue_dly, cpl_dly, with_req);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t v;
        logic [31:0] a;
        vecs[0] = '{32'h0001_2340, 1'b0, 3'd0, 1'b0, 4'd0, 0, 0, 3, 4'h5, 2, 32'h2,     32'h08D, 1'b0};
        vecs[1] = '{32'h0001_2340, 1'b0, 3'd0, 1'b0, 4'd0, 3, 1, 2, 4'hA, 0, 32'h2,     32'h08D, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b1, 3'd7, 1'b1, 4'hF, 2, 2, 1, 4'hF, 1, 32'h1FFFF, 32'h1FF, 1'b0};
        vecs[3] = '{32'h0000_7FC0, 1'b1, 3'd3, 1'b0, 4'd0, 1, 0, 7, 4'h0, 0, 32'h0,     32'h1FF, 1'b0};
        vecs[4] = '{32'h8000_003F, 1'b0, 3'd0, 1'b1, 4'd9, 2, 3, 8, 4'h3, 0, 32'h10000, 32'h000, 1'b1};
        vecs[5] = '{32'h0000_8000, 1'b1, 3'd5, 1'b1, 4'd1, 0, 0, 9, 4'hC, 3, 32'h1,     32'h000, 1'b1};

        #2;
        check_all_zero("reset");
        cyc();
        rst = 1'b1;

        for (int i = 0; i < 6; i++) do_txn(i, vecs[i]);

        // Flush and request arrive together: flush goes first, request follows.
        a = 32'h1234_5678;
        do_flush(0, 2, 1, 1'b1, a);
        run_issue(1'b0, 3'd0, 1'b0, 4'd0, 0, 0, model_tag(a), model_set(a));
        run_way(2, 4'h6, 1'b1);
        run_rsp(0, 4'h6);
        $display("txn 6 addr=%08h after flush", a);
        do_flush(1, 0, 0, 1'b0, 32'h0);

        // Reset while waiting for the way result, then a late way_out is spurious.
        send_req(32'h0ABC_DEC0, 1'b0, 3'd0, 1'b0, 4'd0);
        tag_in_ready = 1'b1;
        set_in_ready = 1'b1;
        settle();
        cyc();
        tag_in_ready = 1'b0;
        set_in_ready = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        cyc();
        rst = 1'b1;
        way_out_valid = 1'b1;
        way_out = 4'h9;
        cyc();
        way_out_valid = 1'b0;
        settle();
        chk("spurious_way", err_spurious, 1);
        chk("spurious_no_rsp", rsp_valid, 0);
        $display("reset txn: late way_out after reset");
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        err_model = 1'b0;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) do_flush(100 + n, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 32'h0);
            v.addr = $urandom;
            v.hs = 1'($urandom);
            v.st = 3'($urandom);
            v.hc = 1'($urandom);
            v.cn = 4'($urandom);
            v.stall = $urandom_range(0, 3);
            v.sel = $urandom_range(0, 3);
            v.lat = $urandom_range(1, 10);
            v.way = 4'($urandom);
            v.rdly = $urandom_range(0, 3);
            v.exp_tag = model_tag(v.addr);
            v.exp_set = model_set(v.addr);
            if (v.lat > LAT_MAX) err_model = 1'b1;
            v.exp_err = err_model;
            do_txn(100 + n, v);
        end
        chk("no_spurious_random", err_spurious, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
